bcd_updown_counter: RTL and testbench
=====================================

# bcd_updown_counter

Synchronous, presettable, cascadable BCD up/down counter of `DIGITS` decades, clocked from one edge. It is the count-down/preset counterpart to the ripple decade counter in the BCD counter family. Designs that need both counting directions use it: countdown timers and odd/even stepping counters. It also feeds the 7-segment display path, and it produces terminal-count carry and borrow for chaining instances.

## Interface
- `DIGITS`, default 2: number of BCD decades; legal range 1–8.
- `CP` input 1: clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset; clears all digits to 0.
- `load` input 1: synchronous parallel load of `D`.
- `set9` input 1: synchronous preset of every digit to 9.
- `D` input 4·DIGITS: load value; digit k is `D[4k+3:4k]`, digit 0 is least significant.
- `up` input 1: count-up enable.
- `down` input 1: count-down enable.
- `Q` output 4·DIGITS: current count, same packing as `D`.
- `co` output 1: carry-out; high when `up` counting is active and the count is all 9s.
- `bo` output 1: borrow-out; high when `down` counting is active and the count is all 0s.
- `load_err` output 1: registered one-cycle flag that a loaded digit exceeded 9.

## Operation
- Priority per rising edge: `load` > `set9` > count > hold.
- `load`:
  - Each digit of `D` that is ≤ 9 is loaded unchanged.
  - Each digit that is > 9 is loaded as 0.
  - `load_err` is 1 next cycle if any digit was > 9, else 0.
- `set9` (without `load`): all digits become 9. `load_err` goes to 0.
- Counting: count up when `up`=1 and `down`=0. Count down when `down`=1 and `up`=0. `up`=`down`=1 holds the count; this is not an error.
- Up step:
  - Digit 0 increments.
  - A digit at 9 wraps to 0 and carries into the next digit.
  - The all-9s count wraps to all 0s.
- Down step:
  - Digit 0 decrements.
  - A digit at 0 wraps to 9 and borrows from the next digit.
  - The all-0s count wraps to all 9s.
- `co` = `up` & ~`down` & ~`load` & ~`set9` & (all digits == 9). This is combinational so instances can cascade synchronously: `co` of one instance drives `up` of the next, and both share `CP`.
- `bo` = `down` & ~`up` & ~`load` & ~`set9` & (all digits == 0). This is combinational.
- `load_err` is 0 on any cycle without `load`.
- Digit values 10–15 are never reachable in `Q`.

## Timing
- Reset values: `Q` = 0 and `load_err` = 0.
  - While `rst` is held, `co` = 0.
  - While `rst` is held, `bo` equals `down & ~up & ~load & ~set9`, because the count is all 0s.
- Asserting `rst` mid-count clears `Q` immediately, without waiting for `CP`.
- After `rst` deasserts, the first count occurs on the next rising `CP`.
- Latency: `Q` reflects load, preset or count one cycle after the controlling inputs are sampled.
- `co`/`bo` have zero-cycle latency from inputs and `Q`. They are valid in the same cycle that the wrap occurs on the following edge.
- Carry/borrow between digits is combinational within one cycle. There is no ripple clocking, so all digits update on the same edge.

## Structure
- Shared package `bcd_pkg` holds:
  - `BCD_MAX` = 4'd9
  - `BCD_MIN` = 4'd0
  - a function `bcd_valid(d)` returning d ≤ 9
- Sub-module `bcd_digit`, instantiated `DIGITS` times in a generate loop. It is one decade with:
  - inputs `CP`, `rst`, `load`, `set9`, `d`, `inc`, `dec`
  - outputs `q`, `tc_up` (q == 9), `tc_dn` (q == 0)
- Digit k+1 increments when all lower digits are 9 and the count is up; it decrements when all lower digits are 0 and the count is down.
- The top level derives `co`, `bo` and `load_err`.

## Test plan
- Reset with `DIGITS`=2: assert `rst` during counting → `Q`=0x00 with no clock edge, and `load_err`=0. Release `rst` and pulse `up` for 3 cycles → `Q`=0x03.
- Up count across a decade: load 0x08, then `up` for 3 cycles → `Q` takes 0x09, 0x10, 0x11. Load 0x99 and hold `up` → `co`=1 in the 0x99 cycle, next `Q`=0x00, then `co`=0.
- Down count: load 0x10, then `down` for 2 cycles → `Q`=0x09, 0x08. At 0x00 with `down` → `bo`=1 and next `Q`=0x99.
- Invalid load: `D`=0xA7 with `load` → `Q`=0x07 and `load_err`=1 for exactly one cycle. `D`=0x42 → `Q`=0x42 and `load_err`=0.
- Priority and conflicts:
  - `load`+`set9`+`up` with `D`=0x25 → `Q`=0x25.
  - `set9`+`down` → `Q`=0x99.
  - `up`+`down` together → `Q` holds, with `co`=`bo`=0.
- Cascade: two instances with `DIGITS`=1, where `co`→`up` of the upper instance, the lower is loaded 9 and the upper 3, and `up`=1 → the pair reads 40 after one edge.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD up/down counter family.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_DIGIT_W-1:0] BCD_MIN = 4'd0;

  function automatic logic bcd_valid(input logic [BCD_DIGIT_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control, load data and status bundle of the BCD up/down counter.
interface bcd_updown_counter_if
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) ();

  localparam int unsigned W = DIGITS * BCD_DIGIT_W;

  logic         load;
  logic         set9;
  logic [W-1:0] D;
  logic         up;
  logic         down;
  logic [W-1:0] Q;
  logic         co;
  logic         bo;
  logic         load_err;

  modport master (
    output load, set9, D, up, down,
    input  Q, co, bo, load_err
  );

  modport slave (
    input  load, set9, D, up, down,
    output Q, co, bo, load_err
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD decade: load (invalid digits forced to 0), preset to 9, and wrapping
// increment/decrement, with terminal-count flags for the neighbouring decade.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic                   CP,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   set9,
  input  logic [BCD_DIGIT_W-1:0] d,
  input  logic                   inc,
  input  logic                   dec,
  output logic [BCD_DIGIT_W-1:0] q,
  output logic                   tc_up,
  output logic                   tc_dn
);

  logic [BCD_DIGIT_W-1:0] q_q;
  logic [BCD_DIGIT_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = bcd_valid(d) ? d : BCD_MIN;
    end else if (set9) begin
      q_d = BCD_MAX;
    end else if (inc) begin
      q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + BCD_DIGIT_W'(1);
    end else if (dec) begin
      q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - BCD_DIGIT_W'(1);
    end
  end

  always_ff @(posedge CP or posedge rst) begin
    if (rst) begin
      q_q <= BCD_MIN;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign tc_up = (q_q == BCD_MAX);
  assign tc_dn = (q_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter.sv
// Synchronous presettable BCD up/down counter of DIGITS decades with
// combinational carry/borrow out for same-clock cascading.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                 CP,
  input  logic                 rst,
  bcd_updown_counter_if.slave  bus
);

  localparam int unsigned W = DIGITS * BCD_DIGIT_W;

  logic              count_up;
  logic              count_dn;
  logic              ctrl_free;
  logic [DIGITS-1:0] tc_up;
  logic [DIGITS-1:0] tc_dn;
  logic [DIGITS-1:0] inc;
  logic [DIGITS-1:0] dec;
  logic [DIGITS-1:0] bad;
  logic [DIGITS:0]   all9;
  logic [DIGITS:0]   all0;
  logic [W-1:0]      q_all;
  logic              load_err_q;
  logic              load_err_d;

  // Opposing enables cancel into a hold.
  assign count_up  = bus.up & ~bus.down;
  assign count_dn  = bus.down & ~bus.up;
  assign ctrl_free = ~bus.load & ~bus.set9;

  // all9[k]/all0[k]: every decade below k sits at its terminal value.
  assign all9[0] = 1'b1;
  assign all0[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign inc[k]    = count_up & all9[k];
    assign dec[k]    = count_dn & all0[k];
    assign all9[k+1] = all9[k] & tc_up[k];
    assign all0[k+1] = all0[k] & tc_dn[k];
    assign bad[k]    = ~bcd_valid(bus.D[BCD_DIGIT_W*k +: BCD_DIGIT_W]);

    bcd_digit u_digit (
      .CP    (CP),
      .rst   (rst),
      .load  (bus.load),
      .set9  (bus.set9),
      .d     (bus.D[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
      .inc   (inc[k]),
      .dec   (dec[k]),
      .q     (q_all[BCD_DIGIT_W*k +: BCD_DIGIT_W]),
      .tc_up (tc_up[k]),
      .tc_dn (tc_dn[k])
    );
  end

  assign load_err_d = bus.load & (|bad);

  always_ff @(posedge CP or posedge rst) begin
    if (rst) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign bus.Q        = q_all;
  assign bus.co       = count_up & ctrl_free & all9[DIGITS];
  assign bus.bo       = count_dn & ctrl_free & all0[DIGITS];
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter: a decimal reference model queues the
// expected count per edge; a separate single-decade pair checks cascading.
module tb_bcd_updown_counter;

  localparam int unsigned DIGITS = 2;
  localparam int unsigned W      = DIGITS * 4;
  localparam int unsigned MOD    = 10 ** DIGITS;

  typedef struct packed {
    logic [W-1:0] q;
    logic         err;
  } exp_t;

  typedef struct packed {
    logic         ld;
    logic         s9;
    logic [W-1:0] d;
    logic         u;
    logic         dn;
  } stim_t;

  logic CP = 1'b0;
  logic rst;
  always #5 CP = ~CP;

  bcd_updown_counter_if #(.DIGITS(DIGITS)) bus ();
  bcd_updown_counter #(.DIGITS(DIGITS)) dut (.CP(CP), .rst(rst), .bus(bus));

  bcd_updown_counter_if #(.DIGITS(1)) lo_bus ();
  bcd_updown_counter_if #(.DIGITS(1)) hi_bus ();
  bcd_updown_counter #(.DIGITS(1)) dut_lo (.CP(CP), .rst(rst), .bus(lo_bus));
  bcd_updown_counter #(.DIGITS(1)) dut_hi (.CP(CP), .rst(rst), .bus(hi_bus));
  assign hi_bus.up = lo_bus.co;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  int unsigned m      = 0;
  logic        exp_co;
  logic        exp_bo;

  function automatic int unsigned to_int(input logic [W-1:0] b);
    int unsigned v = 0;
    for (int k = DIGITS - 1; k >= 0; k--) v = v * 10 + int'(b[4*k +: 4]);
    return v;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Drive one cycle of inputs, predict flags now and the count after the edge.
  task automatic apply(input logic ld, input logic s9, input logic [W-1:0] d,
                       input logic u, input logic dn);
    exp_t         e;
    logic [W-1:0] s = d;
    bus.load = ld; bus.set9 = s9; bus.D = d; bus.up = u; bus.down = dn;
    exp_co = u & ~dn & ~ld & ~s9 & (m == MOD - 1);
    exp_bo = dn & ~u & ~ld & ~s9 & (m == 0);
    e.err  = 1'b0;
    if (ld) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (s[4*k +: 4] > 4'd9) begin
          s[4*k +: 4] = 4'd0;
          e.err = 1'b1;
        end
      end
      m = to_int(s);
    end else if (s9) begin
      m = MOD - 1;
    end else if (u && !dn) begin
      m = (m + 1) % MOD;
    end else if (dn && !u) begin
      m = (m + MOD - 1) % MOD;
    end
    e.q = to_bcd(m);
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    bus.load = 0; bus.set9 = 0; bus.D = '0; bus.up = 0; bus.down = 0;
    #2;
    checks++;
    if (bus.Q !== '0 || bus.load_err !== 1'b0 || bus.co !== 1'b0 || bus.bo !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: Q=%h err=%b co=%b bo=%b expected 00 0 0 0", bus.Q, bus.load_err, bus.co, bus.bo);
    end
    bus.down = 1'b1;
    #1;
    checks++;
    if (bus.bo !== 1'b1 || bus.co !== 1'b0) begin
      errors++;
      $display("FAIL reset_bo: bo=%b co=%b expected 1 0", bus.bo, bus.co);
    end
    @(posedge CP); #1;
    rst = 1'b0;
    m   = 0;
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b0, '0, 1'b1, 1'b0);
      #1;
      checks++;
      if (bus.co !== exp_co || bus.bo !== exp_bo) begin
        errors++;
        $display("FAIL reset_flags: co=%b bo=%b expected %b %b", bus.co, bus.bo, exp_co, exp_bo);
      end
      @(posedge CP); #1;
      e = sb.pop_front();
      checks++;
      if (bus.Q !== e.q || bus.load_err !== e.err) begin
        errors++;
        $display("FAIL reset_pre_count: Q=%h err=%b expected %h %b", bus.Q, bus.load_err, e.q, e.err);
      end
    end
    // Asynchronous clear in the middle of a clock phase.
    apply(1'b0, 1'b0, '0, 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.Q !== '0 || bus.load_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: Q=%h err=%b expected 00 0", bus.Q, bus.load_err);
    end
    sb.delete();
    m   = 0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, '0, 1'b1, 1'b0);
      @(posedge CP); #1;
      e = sb.pop_front();
      checks++;
      if (bus.Q !== e.q) begin
        errors++;
        $display("FAIL reset_recount: Q=%h expected %h", bus.Q, e.q);
      end
    end
    checks++;
    if (bus.Q !== 8'h03) begin
      errors++;
      $display("FAIL reset_recount_final: Q=%h expected 03", bus.Q);
    end
  endtask

  task automatic test_up();
    exp_t  e;
    stim_t st[7];
    st = '{{1'b1, 1'b0, 8'h08, 1'b0, 1'b0}, {1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
           {1'b0, 1'b0, 8'h00, 1'b1, 1'b0}, {1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
           {1'b1, 1'b0, 8'h99, 1'b0, 1'b0}, {1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
           {1'b0, 1'b0, 8'h00, 1'b1, 1'b0}};
    for (int i = 0; i < 7; i++) begin
      apply(st[i].ld, st[i].s9, st[i].d, st[i].u, st[i].dn);
      #1;
      checks++;
      if (bus.co !== exp_co || bus.bo !== exp_bo) begin
        errors++;
        $display("FAIL up_flags[%0d]: co=%b bo=%b expected %b %b", i, bus.co, bus.bo, exp_co, exp_bo);
      end
      if (i == 5) begin
        checks++;
        if (bus.co !== 1'b1) begin
          errors++;
          $display("FAIL up_co_at_99: co=%b expected 1", bus.co);
        end
      end
      @(posedge CP); #1;
      e = sb.pop_front();
      checks++;
      if (bus.Q !== e.q || bus.load_err !== e.err) begin
        errors++;
        $display("FAIL up_count[%0d]: Q=%h err=%b expected %h %b", i, bus.Q, bus.load_err, e.q, e.err);
      end
      if (i == 3) begin
        checks++;
        if (bus.Q !== 8'h11) begin
          errors++;
          $display("FAIL up_decade: Q=%h expected 11", bus.Q);
        end
      end
    end
  endtask

  task automatic test_down();
    exp_t  e;
    stim_t st[5];
    st = '{{1'b1, 1'b0, 8'h10, 1'b0, 1'b0}, {1'b0, 1'b0, 8'h00, 1'b0, 1'b1},
           {1'b0, 1'b0, 8'h00, 1'b0, 1'b1}, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0},
           {1'b0, 1'b0, 8'h00, 1'b0, 1'b1}};
    for (int i = 0; i < 5; i++) begin
      apply(st[i].ld, st[i].s9, st[i].d, st[i].u, st[i].dn);
      #1;
      checks++;
      if (bus.co !== exp_co || bus.bo !== exp_bo) begin
        errors++;
        $display("FAIL down_flags[%0d]: co=%b bo=%b expected %b %b", i, bus.co, bus.bo, exp_co, exp_bo);
      end
      @(posedge CP); #1;
      e = sb.pop_front();
      checks++;
      if (bus.Q !== e.q || bus.load_err !== e.err) begin
        errors++;
        $display("FAIL down_count[%0d]: Q=%h err=%b expected %h %b", i, bus.Q, bus.load_err, e.q, e.err);
      end
      if (i == 2 && bus.Q !== 8'h08) begin
        errors++;
        $display("FAIL down_decade: Q=%h expected 08", bus.Q);
      end
      if (i == 4 && bus.Q !== 8'h99) begin
        errors++;
        $display("FAIL down_wrap: Q=%h expected 99", bus.Q);
      end
    end
    checks += 2;
  endtask

  task automatic test_invalid_load();
    exp_t  e;
    stim_t st[5];
    st = '{{1'b1, 1'b0, 8'hA7, 1'b0, 1'b0}, {1'b0, 1'b0, 8'h00, 1'b0, 1'b0},
           {1'b1, 1'b0, 8'h42, 1'b0, 1'b0}, {1'b1, 1'b0, 8'h9F, 1'b1, 1'b0},
           {1'b0, 1'b1, 8'hFF, 1'b0, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      apply(st[i].ld, st[i].s9, st[i].d, st[i].u, st[i].dn);
      @(posedge CP); #1;
      e = sb.pop_front();
      checks++;
      if (bus.Q !== e.q || bus.load_err !== e.err) begin
        errors++;
        $display("FAIL invalid_load[%0d]: Q=%h err=%b expected %h %b", i, bus.Q, bus.load_err, e.q, e.err);
      end
      if (i == 0 && (bus.Q !== 8'h07 || bus.load_err !== 1'b1)) begin
        errors++;
        $display("FAIL invalid_load_a7: Q=%h err=%b expected 07 1", bus.Q, bus.load_err);
      end
    end
    checks++;
  endtask

  task automatic test_priority();
    exp_t  e;
    stim_t st[5];
    st = '{{1'b1, 1'b1, 8'h25, 1'b1, 1'b0}, {1'b0, 1'b1, 8'h00, 1'b0, 1'b1},
           {1'b0, 1'b0, 8'h00, 1'b1, 1'b1}, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0},
           {1'b0, 1'b0, 8'h00, 1'b1, 1'b1}};
    for (int i = 0; i < 5; i++) begin
      apply(st[i].ld, st[i].s9, st[i].d, st[i].u, st[i].dn);
      #1;
      checks++;
      if (bus.co !== exp_co || bus.bo !== exp_bo) begin
        errors++;
        $display("FAIL prio_flags[%0d]: co=%b bo=%b expected %b %b", i, bus.co, bus.bo, exp_co, exp_bo);
      end
      @(posedge CP); #1;
      e = sb.pop_front();
      checks++;
      if (bus.Q !== e.q || bus.load_err !== e.err) begin
        errors++;
        $display("FAIL prio_count[%0d]: Q=%h err=%b expected %h %b", i, bus.Q, bus.load_err, e.q, e.err);
      end
      if (i == 0 && bus.Q !== 8'h25) begin
        errors++;
        $display("FAIL prio_load_wins: Q=%h expected 25", bus.Q);
      end
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 60; i++) begin
      apply(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 9) == 0),
            W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      checks++;
      if (bus.co !== exp_co || bus.bo !== exp_bo) begin
        errors++;
        $display("FAIL b2b_flags[%0d]: co=%b bo=%b expected %b %b", i, bus.co, bus.bo, exp_co, exp_bo);
      end
      @(posedge CP); #1;
      e = sb.pop_front();
      checks++;
      if (bus.Q !== e.q || bus.load_err !== e.err) begin
        errors++;
        $display("FAIL b2b_count[%0d]: Q=%h err=%b expected %h %b", i, bus.Q, bus.load_err, e.q, e.err);
      end
    end
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(posedge CP); #1;
    e = sb.pop_front();
    checks++;
    if (bus.Q !== e.q) begin
      errors++;
      $display("FAIL b2b_idle: Q=%h expected %h", bus.Q, e.q);
    end
  endtask

  task automatic test_cascade();
    lo_bus.load = 1'b1; lo_bus.D = 4'h9; lo_bus.up = 1'b0;
    hi_bus.load = 1'b1; hi_bus.D = 4'h3;
    @(posedge CP); #1;
    checks++;
    if ({hi_bus.Q, lo_bus.Q} !== 8'h39) begin
      errors++;
      $display("FAIL cascade_load: pair=%h expected 39", {hi_bus.Q, lo_bus.Q});
    end
    lo_bus.load = 1'b0; hi_bus.load = 1'b0; lo_bus.up = 1'b1;
    #1;
    checks++;
    if (lo_bus.co !== 1'b1 || hi_bus.co !== 1'b0) begin
      errors++;
      $display("FAIL cascade_co: lo_co=%b hi_co=%b expected 1 0", lo_bus.co, hi_bus.co);
    end
    @(posedge CP); #1;
    checks++;
    if ({hi_bus.Q, lo_bus.Q} !== 8'h40) begin
      errors++;
      $display("FAIL cascade_step: pair=%h expected 40", {hi_bus.Q, lo_bus.Q});
    end
    lo_bus.up = 1'b0;
  endtask

  initial begin
    lo_bus.load = 0; lo_bus.set9 = 0; lo_bus.D = '0; lo_bus.up = 0; lo_bus.down = 0;
    hi_bus.load = 0; hi_bus.set9 = 0; hi_bus.D = '0; hi_bus.down = 0;
    test_reset();
    test_up();
    test_down();
    test_invalid_load();
    test_priority();
    test_back_to_back();
    test_cascade();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
